// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: frame sequencer behind the WS2812 decode pipeline.
// The first NUM_PIXELS pixels of a frame are assembled MSB first into
// BITS_PER_PIXEL-bit words. Every later bit is forwarded downstream. A treset
// strobe re-arms the sequencer for the next frame.
// Optional feature macro: LEAF_FRAME_STATS_EN adds saturating frame/error
// counters. Without the macro both count ports are tied to zero.
module ws2812_frame_ctrl #(
    parameter int NUM_PIXELS     = 1,
    parameter int BITS_PER_PIXEL = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      decode_bit,
    input  logic                      valid_strobe,
    input  logic                      treset,
    output logic [BITS_PER_PIXEL-1:0] pixel_data,
    output logic [7:0]                pixel_index,
    output logic                      pixel_valid,
    output logic                      fwd_bit,
    output logic                      fwd_valid,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      busy,
    output logic [15:0]               frame_count,
    output logic [15:0]               err_count
);

    localparam int                CNT_W    = $clog2(BITS_PER_PIXEL + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BITS_PER_PIXEL);
    localparam logic [7:0]        LAST_PIX = 8'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        FORWARD = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;
    logic [BITS_PER_PIXEL-1:0] asm_r;
    logic [BITS_PER_PIXEL-1:0] asm_shift_s;
    logic [CNT_W-1:0]          bit_cnt_r;
    logic [CNT_W-1:0]          bit_cnt_inc_s;
    logic [7:0]                pix_cnt_r;
    logic                      shift_s;
    logic                      pix_done_s;
    logic                      fwd_s;
    logic                      done_s;
    logic                      err_s;
    logic                      clear_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARMED;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control. An ARMED strobe is handled like a
    // capture strobe, because the counters are already clear in ARMED.
    always_comb begin
        state_next_s  = state_r;
        shift_s       = 1'b0;
        pix_done_s    = 1'b0;
        fwd_s         = 1'b0;
        done_s        = 1'b0;
        err_s         = 1'b0;
        clear_s       = 1'b0;
        asm_shift_s   = {asm_r[BITS_PER_PIXEL-2:0], decode_bit};
        bit_cnt_inc_s = bit_cnt_r + CNT_W'(1);
        case (state_r)
            ARMED, CAPTURE: begin
                if (treset) begin
                    clear_s      = 1'b1;
                    err_s        = (state_r == CAPTURE);
                    state_next_s = ARMED;
                end else if (valid_strobe) begin
                    shift_s = 1'b1;
                    if (bit_cnt_inc_s == LAST_BIT) begin
                        pix_done_s = 1'b1;
                        if (pix_cnt_r == LAST_PIX) begin
                            state_next_s = FORWARD;
                        end else begin
                            state_next_s = CAPTURE;
                        end
                    end else begin
                        state_next_s = CAPTURE;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            FORWARD: begin
                if (treset) begin
                    clear_s      = 1'b1;
                    done_s       = 1'b1;
                    state_next_s = ARMED;
                end else if (valid_strobe) begin
                    fwd_s = 1'b1;
                end else begin
                    state_next_s = FORWARD;
                end
            end
            default: begin
                clear_s      = 1'b1;
                state_next_s = ARMED;
            end
        endcase
    end

    // Assembly register, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_r       <= '0;
            bit_cnt_r   <= '0;
            pix_cnt_r   <= 8'd0;
            pixel_data  <= '0;
            pixel_index <= 8'd0;
            pixel_valid <= 1'b0;
            fwd_bit     <= 1'b0;
            fwd_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (clear_s) begin
                asm_r     <= '0;
                bit_cnt_r <= '0;
                pix_cnt_r <= 8'd0;
            end else if (shift_s) begin
                asm_r <= asm_shift_s;
                if (pix_done_s) begin
                    bit_cnt_r   <= '0;
                    pix_cnt_r   <= pix_cnt_r + 8'd1;
                    pixel_data  <= asm_shift_s;
                    pixel_index <= pix_cnt_r;
                end else begin
                    bit_cnt_r <= bit_cnt_inc_s;
                end
            end
            if (fwd_s) begin
                fwd_bit <= decode_bit;
            end
            pixel_valid <= pix_done_s;
            fwd_valid   <= fwd_s;
            frame_done  <= done_s;
            frame_err   <= err_s;
            busy        <= (state_next_s != ARMED);
        end
    end

`ifdef LEAF_FRAME_STATS_EN
    logic [15:0] frame_count_r;
    logic [15:0] err_count_r;

    // Saturating frame and error statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_r <= 16'd0;
            err_count_r   <= 16'd0;
        end else begin
            if (done_s && (frame_count_r != 16'hFFFF)) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
            if (err_s && (err_count_r != 16'hFFFF)) begin
                err_count_r <= err_count_r + 16'd1;
            end
        end
    end

    assign frame_count = frame_count_r;
    assign err_count   = err_count_r;
`else
    assign frame_count = 16'd0;
    assign err_count   = 16'd0;
`endif

endmodule
